// File: rtl/encode_mul_pkg.sv
// encode_mul_pkg: shared types and constants for the encode_mul_pipe slice.
//   mode_t      - per-beat mode bits sampled with the operands
//   acc_mode_t  - accumulator control bits that travel down the pipe
//   prod_width  - full exact product width for a din0/din1 pair
//   sat_max/min - two's-complement saturation limits for a given width
//   NUM_STAGE_MIN/MAX - legal pipeline depth, checked at elaboration
package encode_mul_pkg;

  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 4;

  typedef struct packed {
    logic din1_signed;
    logic acc_en;
    logic acc_first;
  } mode_t;

  // din1_signed is consumed where the product is formed, so only the
  // accumulator controls need to ride along with the product.
  typedef struct packed {
    logic acc_en;
    logic acc_first;
  } acc_mode_t;

  // The extra bit holds din1 zero-extended as a signed operand.
  function automatic int prod_width(input int din0_w, input int din1_w);
    return din0_w + din1_w + 1;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/encode_mul_pipe_if.sv
// encode_mul_pipe_if: operand/result bundle for encode_mul_pipe.
//   master: drives in_valid, mode bits, din0, din1; receives dout, out_valid, ovf
//   slave : the multiplier side
// Packed lane vectors carry lane 0 in the LSBs.
interface encode_mul_pipe_if #(
  parameter int LANES      = 2,
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 12,
  parameter int DOUT_WIDTH = 26
) ();

  logic                        in_valid;
  logic                        din1_signed;
  logic                        acc_en;
  logic                        acc_first;
  logic [LANES*DIN0_WIDTH-1:0] din0;
  logic [LANES*DIN1_WIDTH-1:0] din1;
  logic [LANES*DOUT_WIDTH-1:0] dout;
  logic                        out_valid;
  logic [LANES-1:0]            ovf;

  modport master (
    output in_valid, din1_signed, acc_en, acc_first, din0, din1,
    input  dout, out_valid, ovf
  );

  modport slave (
    input  in_valid, din1_signed, acc_en, acc_first, din0, din1,
    output dout, out_valid, ovf
  );

endinterface

// File: rtl/encode_mul_lane.sv
// encode_mul_lane: one lane of the encoder multiplier.
//   din0 (signed) x din1 (signed or zero-extended) -> exact product,
//   NUM_STAGE-1 product registers, then a final register stage that narrows
//   to DOUT_WIDTH and optionally accumulates.
// Ports: clk, reset (async, active-low), ce, din0, din1, din1_signed (input
//   stage), fin_vld/fin_acc (final-stage valid and accumulator controls from
//   the shared pipe), dout, ovf.
// Build option: ENCODE_MUL_SAT_EN selects saturating narrowing/accumulation
//   with an overflow flag; otherwise results wrap and ovf is 0.
module encode_mul_lane
  import encode_mul_pkg::*;
#(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 12,
  parameter int DOUT_WIDTH = 26,
  parameter int NUM_STAGE  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic        [DIN1_WIDTH-1:0] din1,
  input  logic                         din1_signed,
  input  logic                         fin_vld,
  input  acc_mode_t                    fin_acc,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         ovf
);

  localparam int P  = prod_width(DIN0_WIDTH, DIN1_WIDTH);
  localparam int EW = (P > DOUT_WIDTH) ? P : DOUT_WIDTH;

  logic signed [DIN1_WIDTH:0]   din1_ext;
  logic signed [P-1:0]          prod_c;
  logic signed [P-1:0]          prod_fin;
  logic signed [DOUT_WIDTH-1:0] n_val;
  logic signed [DOUT_WIDTH-1:0] a_sum;
  logic signed [DOUT_WIDTH-1:0] acc;
  logic signed [DOUT_WIDTH-1:0] dout_r;

  assign din1_ext = {din1_signed & din1[DIN1_WIDTH-1], din1};
  assign prod_c   = P'(din0) * P'(din1_ext);

  // ---- product pipe: stages 1 .. NUM_STAGE-1 ----
  generate
    if (NUM_STAGE == 1) begin : g_direct
      assign prod_fin = prod_c;
    end else begin : g_pipe
      logic signed [P-1:0] prod_p [NUM_STAGE-1];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < NUM_STAGE - 1; i++) prod_p[i] <= '0;
        end else if (ce) begin
          prod_p[0] <= prod_c;
          for (int i = 1; i < NUM_STAGE - 1; i++) prod_p[i] <= prod_p[i-1];
        end
      end
      assign prod_fin = prod_p[NUM_STAGE-2];
    end
  endgenerate

`ifdef ENCODE_MUL_SAT_EN
  localparam logic signed [DOUT_WIDTH-1:0] SAT_HI = DOUT_WIDTH'(sat_max(DOUT_WIDTH));
  localparam logic signed [DOUT_WIDTH-1:0] SAT_LO = DOUT_WIDTH'(sat_min(DOUT_WIDTH));

  logic n_ovf;
  logic a_ovf;
  logic ovf_r;

  // Returns {clamped, value}.
  function automatic logic [DOUT_WIDTH:0] narrow_sat(input logic signed [P-1:0] p);
    logic signed [EW-1:0] pe;
    logic signed [EW-1:0] hi;
    logic signed [EW-1:0] lo;
    pe = EW'(p);
    hi = EW'(SAT_HI);
    lo = EW'(SAT_LO);
    if (pe > hi) return {1'b1, SAT_HI};
    if (pe < lo) return {1'b1, SAT_LO};
    return {1'b0, pe[DOUT_WIDTH-1:0]};
  endfunction

  // One guard bit exposes overflow: the top two sum bits disagree.
  function automatic logic [DOUT_WIDTH:0] add_sat(input logic signed [DOUT_WIDTH-1:0] a,
                                                  input logic signed [DOUT_WIDTH-1:0] b);
    logic signed [DOUT_WIDTH:0] s;
    s = $signed({a[DOUT_WIDTH-1], a}) + $signed({b[DOUT_WIDTH-1], b});
    if (s[DOUT_WIDTH] != s[DOUT_WIDTH-1]) return {1'b1, (s[DOUT_WIDTH] ? SAT_LO : SAT_HI)};
    return {1'b0, s[DOUT_WIDTH-1:0]};
  endfunction

  always_comb begin
    {n_ovf, n_val} = narrow_sat(prod_fin);
    {a_ovf, a_sum} = add_sat(acc, n_val);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_r <= 1'b0;
    end else if (ce && fin_vld) begin
      ovf_r <= n_ovf | (fin_acc.acc_en & ~fin_acc.acc_first & a_ovf);
    end
  end

  assign ovf = ovf_r;
`else
  function automatic logic signed [DOUT_WIDTH-1:0] narrow_wrap(input logic signed [P-1:0] p);
    logic signed [EW-1:0] pe;
    pe = EW'(p);
    return pe[DOUT_WIDTH-1:0];
  endfunction

  always_comb begin
    n_val = narrow_wrap(prod_fin);
    a_sum = acc + n_val;
  end

  assign ovf = 1'b0;
`endif

  // ---- final stage: narrowing / accumulate into dout ----
  // Bubbles leave both the accumulator and dout untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      dout_r <= '0;
    end else if (ce && fin_vld) begin
      if (!fin_acc.acc_en) begin
        dout_r <= n_val;
      end else if (fin_acc.acc_first) begin
        acc    <= n_val;
        dout_r <= n_val;
      end else begin
        acc    <= a_sum;
        dout_r <= a_sum;
      end
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/encode_mul_pipe.sv
// encode_mul_pipe: LANES-wide pipelined multiply(-accumulate) unit.
// Ports: clk, reset (async assert, active-low), ce (clock enable, freezes all
//   stages when low), bus (encode_mul_pipe_if.slave: in_valid, din1_signed,
//   acc_en, acc_first, din0, din1 in; dout, out_valid, ovf out).
// A beat presented with in_valid=1 is captured on a ce=1 edge and its result
// is registered on dout/out_valid NUM_STAGE ce=1 edges after being presented.
// Build option: ENCODE_MUL_SAT_EN (saturating results and per-lane ovf).
module encode_mul_pipe
  import encode_mul_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 12,
  parameter int DOUT_WIDTH = 26,
  parameter int NUM_STAGE  = 2
) (
  input logic               clk,
  input logic               reset,
  input logic               ce,
  encode_mul_pipe_if.slave  bus
);

  generate
    if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_stage
      $error("encode_mul_pipe: NUM_STAGE must be within 1..4");
    end
  endgenerate

  mode_t     mode_in;
  acc_mode_t acc_in;
  acc_mode_t acc_fin;
  logic      vld_fin;
  logic      vld_out;

  assign mode_in = '{din1_signed: bus.din1_signed, acc_en: bus.acc_en, acc_first: bus.acc_first};
  assign acc_in  = '{acc_en: mode_in.acc_en, acc_first: mode_in.acc_first};

  // ---- shared valid/mode pipe: stages 1 .. NUM_STAGE-1 ----
  generate
    if (NUM_STAGE == 1) begin : g_direct
      assign vld_fin = bus.in_valid;
      assign acc_fin = acc_in;
    end else begin : g_pipe
      logic      vld_p  [NUM_STAGE-1];
      acc_mode_t mode_p [NUM_STAGE-1];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < NUM_STAGE - 1; i++) begin
            vld_p[i]  <= 1'b0;
            mode_p[i] <= '0;
          end
        end else if (ce) begin
          vld_p[0]  <= bus.in_valid;
          mode_p[0] <= acc_in;
          for (int i = 1; i < NUM_STAGE - 1; i++) begin
            vld_p[i]  <= vld_p[i-1];
            mode_p[i] <= mode_p[i-1];
          end
        end
      end
      assign vld_fin = vld_p[NUM_STAGE-2];
      assign acc_fin = mode_p[NUM_STAGE-2];
    end
  endgenerate

  // ---- output stage: valid ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_out <= 1'b0;
    end else if (ce) begin
      vld_out <= vld_fin;
    end
  end

  assign bus.out_valid = vld_out;

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      encode_mul_lane #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DIN1_WIDTH (DIN1_WIDTH),
        .DOUT_WIDTH (DOUT_WIDTH),
        .NUM_STAGE  (NUM_STAGE)
      ) u_lane (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .din0        (bus.din0[l*DIN0_WIDTH +: DIN0_WIDTH]),
        .din1        (bus.din1[l*DIN1_WIDTH +: DIN1_WIDTH]),
        .din1_signed (mode_in.din1_signed),
        .fin_vld     (vld_fin),
        .fin_acc     (acc_fin),
        .dout        (bus.dout[l*DOUT_WIDTH +: DOUT_WIDTH]),
        .ovf         (bus.ovf[l])
      );
    end
  endgenerate

endmodule

// File: tb/tb_encode_mul_pipe.sv
// tb_encode_mul_pipe: directed bench for encode_mul_pipe.
// Main DUT: LANES=2, DIN0=14, DIN1=12, DOUT=26, NUM_STAGE=2.
// Narrow DUT: same but DOUT=16, for narrowing/accumulator overflow.
// Expected narrowing results follow ENCODE_MUL_SAT_EN.
module tb_encode_mul_pipe;

  localparam int D0 = 14;
  localparam int D1 = 12;
  localparam int DW = 26;
  localparam int DN = 16;

`ifdef ENCODE_MUL_SAT_EN
  localparam longint N_EXP = 32767;
  localparam longint N_OVF = 1;
  localparam longint A_EXP = 32767;
  localparam longint A_OVF = 1;
`else
  localparam longint N_EXP = -12287;
  localparam longint N_OVF = 0;
  localparam longint A_EXP = -8;
  localparam longint A_OVF = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic ce;

  always #5 clk = ~clk;

  encode_mul_pipe_if #(.LANES(2), .DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .DOUT_WIDTH(DW)) m_if ();
  encode_mul_pipe_if #(.LANES(2), .DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .DOUT_WIDTH(DN)) n_if ();

  encode_mul_pipe #(.LANES(2), .DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .DOUT_WIDTH(DW), .NUM_STAGE(2))
    dut (.clk(clk), .reset(reset), .ce(ce), .bus(m_if.slave));

  encode_mul_pipe #(.LANES(2), .DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .DOUT_WIDTH(DN), .NUM_STAGE(2))
    dut_n (.clk(clk), .reset(reset), .ce(ce), .bus(n_if.slave));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [D0-1:0] a0;
    logic [D1-1:0] b0;
    logic [D0-1:0] a1;
    logic [D1-1:0] b1;
    logic          sgn;
    logic          ae;
    logic          af;
    longint        e0;
    longint        e1;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic longint m_lane(input int l);
    logic signed [DW-1:0] v;
    v = m_if.dout[l*DW +: DW];
    return longint'(v);
  endfunction

  function automatic longint n_lane(input int l);
    logic signed [DN-1:0] v;
    v = n_if.dout[l*DN +: DN];
    return longint'(v);
  endfunction

  task automatic drive_m(input logic [D0-1:0] a0, input logic [D1-1:0] b0,
                         input logic [D0-1:0] a1, input logic [D1-1:0] b1,
                         input logic v, input logic sgn, input logic ae, input logic af);
    m_if.in_valid    = v;
    m_if.din1_signed = sgn;
    m_if.acc_en      = ae;
    m_if.acc_first   = af;
    m_if.din0        = {a1, a0};
    m_if.din1        = {b1, b0};
  endtask

  task automatic drive_n(input logic [D0-1:0] a0, input logic [D1-1:0] b0,
                         input logic [D0-1:0] a1, input logic [D1-1:0] b1,
                         input logic v, input logic sgn, input logic ae, input logic af);
    n_if.in_valid    = v;
    n_if.din1_signed = sgn;
    n_if.acc_en      = ae;
    n_if.acc_first   = af;
    n_if.din0        = {a1, a0};
    n_if.din1        = {b1, b0};
  endtask

  task automatic idle_m();
    drive_m('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_n();
    drive_n('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           a0        b0        a1        b1       sgn   ae    af    e0         e1
    vecs[0] = '{14'h3FFD, 12'hFFF, 14'd5,    12'd7,   1'b0, 1'b0, 1'b0, -12285,    35};
    vecs[1] = '{14'h3FFD, 12'hFFF, 14'h2000, 12'h800, 1'b1, 1'b0, 1'b0, 3,         16777216};
    vecs[2] = '{14'd7,    12'h7FF, 14'd100,  12'hFFE, 1'b1, 1'b0, 1'b0, 14329,     -200};
    vecs[3] = '{14'd2,    12'd5,   14'h3FFF, 12'd3,   1'b0, 1'b1, 1'b1, 10,        -3};
    vecs[4] = '{14'd4,    12'd5,   14'd1,    12'd1,   1'b0, 1'b1, 1'b0, 30,        -2};
    vecs[5] = '{14'd6,    12'd5,   14'h3FFF, 12'hFFF, 1'b0, 1'b1, 1'b0, 60,        -4097};
    vecs[6] = '{14'd1,    12'd5,   14'd2,    12'd3,   1'b0, 1'b1, 1'b1, 5,         6};
    vecs[7] = '{14'h1FFF, 12'h800, 14'd0,    12'd0,   1'b0, 1'b0, 1'b0, 16775168,  0};
    vecs[8] = '{14'd1,    12'd1,   14'd1,    12'd1,   1'b0, 1'b1, 1'b0, 6,         7};
    vecs[9] = '{14'h2000, 12'hFFF, 14'h1FFF, 12'hFFF, 1'b0, 1'b0, 1'b0, -33546240, 33542145};

    reset = 1'b0;
    ce    = 1'b1;
    idle_m();
    idle_n();
    repeat (2) @(negedge clk);
    check("rst_out_valid", longint'(m_if.out_valid), 0);
    check("rst_dout_l0", m_lane(0), 0);
    check("rst_dout_l1", m_lane(1), 0);
    check("rst_ovf", longint'(m_if.ovf), 0);
    check("rst_n_out_valid", longint'(n_if.out_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Single beats with bubbles: latency, data, one-cycle valid, hold.
    for (int i = 0; i < 10; i++) begin
      drive_m(vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1, 1'b1,
              vecs[i].sgn, vecs[i].ae, vecs[i].af);
      @(negedge clk);
      idle_m();
      check($sformatf("v%0d_early_valid", i), longint'(m_if.out_valid), 0);
      @(negedge clk);
      check($sformatf("v%0d_valid", i), longint'(m_if.out_valid), 1);
      check($sformatf("v%0d_l0", i), m_lane(0), vecs[i].e0);
      check($sformatf("v%0d_l1", i), m_lane(1), vecs[i].e1);
      check($sformatf("v%0d_ovf", i), longint'(m_if.ovf), 0);
      @(negedge clk);
      check($sformatf("v%0d_valid_drop", i), longint'(m_if.out_valid), 0);
      check($sformatf("v%0d_hold_l0", i), m_lane(0), vecs[i].e0);
    end

    // Back-to-back accumulation at full throughput.
    drive_m(14'd2, 12'd5, 14'd1, 12'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive_m(14'd4, 12'd5, 14'd1, 12'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive_m(14'd6, 12'd5, 14'd1, 12'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    check("b2b_0_l0", m_lane(0), 10);
    check("b2b_0_l1", m_lane(1), 1);
    @(negedge clk);
    idle_m();
    check("b2b_1_valid", longint'(m_if.out_valid), 1);
    check("b2b_1_l0", m_lane(0), 30);
    check("b2b_1_l1", m_lane(1), 3);
    @(negedge clk);
    check("b2b_2_valid", longint'(m_if.out_valid), 1);
    check("b2b_2_l0", m_lane(0), 60);
    check("b2b_2_l1", m_lane(1), 6);
    drive_m(14'd1, 12'd5, 14'd2, 12'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    idle_m();
    check("b2b_bubble_valid", longint'(m_if.out_valid), 0);
    @(negedge clk);
    check("restart_l0", m_lane(0), 5);
    check("restart_l1", m_lane(1), 4);
    @(negedge clk);

    // Stall: ce low for 3 cycles with the beat inside the pipe.
    drive_m(14'd3, 12'd3, 14'h3FFF, 12'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    idle_m();
    check("stall_pre_valid", longint'(m_if.out_valid), 0);
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall_frozen_%0d", k), longint'(m_if.out_valid), 0);
    end
    ce = 1'b1;
    @(negedge clk);
    check("stall_valid", longint'(m_if.out_valid), 1);
    check("stall_l0", m_lane(0), 9);
    check("stall_l1", m_lane(1), -2);
    ce = 1'b0;
    @(negedge clk);
    check("stall_valid_held", longint'(m_if.out_valid), 1);
    ce = 1'b1;
    @(negedge clk);
    check("stall_no_dup", longint'(m_if.out_valid), 0);

    // Reset mid-operation with two beats in flight and non-zero accumulators.
    drive_m(14'd1, 12'd1, 14'd1, 12'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive_m(14'd2, 12'd1, 14'd2, 12'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", longint'(m_if.out_valid), 0);
    check("mid_rst_l0", m_lane(0), 0);
    check("mid_rst_l1", m_lane(1), 0);
    idle_m();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_stale_%0d", k), longint'(m_if.out_valid), 0);
    end
    drive_m(14'd7, 12'd1, 14'd1, 12'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    idle_m();
    @(negedge clk);
    check("post_rst_valid", longint'(m_if.out_valid), 1);
    check("post_rst_acc_l0", m_lane(0), 7);
    check("post_rst_acc_l1", m_lane(1), 1);
    @(negedge clk);

    // Narrowing to 16 bits.
    drive_n(14'd8191, 12'hFFF, 14'h3FFE, 12'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    idle_n();
    @(negedge clk);
    check("narrow_valid", longint'(n_if.out_valid), 1);
    check("narrow_l0", n_lane(0), N_EXP);
    check("narrow_l1", n_lane(1), -6);
    check("narrow_ovf0", longint'(n_if.ovf[0]), N_OVF);
    check("narrow_ovf1", longint'(n_if.ovf[1]), 0);
    @(negedge clk);

    // Accumulator overflow in 16 bits: 32764 + 32764.
    drive_n(14'd8191, 12'd4, 14'd0, 12'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive_n(14'd8191, 12'd4, 14'd0, 12'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    idle_n();
    check("accov_first_l0", n_lane(0), 32764);
    check("accov_first_ovf", longint'(n_if.ovf[0]), 0);
    @(negedge clk);
    check("accov_sum_l0", n_lane(0), A_EXP);
    check("accov_sum_ovf", longint'(n_if.ovf[0]), A_OVF);
    check("accov_l1", n_lane(1), 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
